// File: rtl/instruction_encoder_pkg.sv
// Shared instruction-set constants: opcodes, special register indices, word field layout
// and the encoder FSM state encoding.
package instruction_encoder_pkg;

    localparam logic [3:0] OP_ADD           = 4'd0;
    localparam logic [3:0] OP_SUB           = 4'd1;
    localparam logic [3:0] OP_MUL           = 4'd2;
    localparam logic [3:0] OP_DIV           = 4'd3;
    localparam logic [3:0] OP_CMP           = 4'd4;
    localparam logic [3:0] OP_AND           = 4'd5;
    localparam logic [3:0] OP_OR            = 4'd6;
    localparam logic [3:0] OP_NOT           = 4'd7;
    localparam logic [3:0] OP_TEST          = 4'd8;
    localparam logic [3:0] OP_MOVE          = 4'd9;
    localparam logic [3:0] OP_SHIFT         = 4'd10;
    localparam logic [3:0] OP_LOAD_STORE    = 4'd11;
    localparam logic [3:0] OP_LOAD_CONSTANT = 4'd12;
    localparam logic [3:0] OP_CALL          = 4'd13;
    localparam logic [3:0] OP_INTERRUPT     = 4'd14;
    // Opcodes above this one are undefined.
    localparam logic [3:0] OP_LAST          = OP_INTERRUPT;

    localparam logic [4:0] REG_SP  = 5'd28;
    localparam logic [4:0] REG_LR  = 5'd29;
    localparam logic [4:0] REG_PC  = 5'd30;
    localparam logic [4:0] REG_PSW = 5'd31;

    // Word layout: opcode [31:28], destination [27:23]; the operand fields below depend on the class.
    // Arithmetic keeps its source register and immediate in one union selected by the IS_IMMEDIATE bit.
    localparam int OPCODE_LSB              = 28;
    localparam int DEST_LSB                = 23;
    localparam int SRC_LSB                 = 18;
    localparam int ARITHMETIC_IS_IMMEDIATE = 22;
    localparam int ARITHMETIC_SRC_LSB      = 17;
    localparam int ARITHMETIC_IMMEDIATE_W  = 18;
    localparam int MOVE_SHIFT_IS_IMMEDIATE = 17;
    localparam int SHIFT_IS_LEFT           = 16;
    localparam int MOVE_SHIFT_IMMEDIATE_W  = 5;
    localparam int LOAD_STORE_MODE_LSB     = 15;
    localparam int LOAD_STORE_IMMEDIATE_W  = 10;
    localparam int LDC_IS_HIGH             = 16;
    localparam int LDC_CONSTANT_W          = 16;
    localparam int CALL_IMMEDIATE_W        = 19;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        LDC_LOW,
        LDC_HIGH
    } state_t;

endpackage

// File: rtl/immediate_range_check.sv
// Combinational check that an immediate fits the field its opcode class encodes it into.
module immediate_range_check
    import instruction_encoder_pkg::*;
(
    input  logic [3:0]         opcode,
    input  logic               is_immediate,
    input  logic signed [31:0] immediate,
    output logic               in_range
);

    // Representable iff every bit above the field's sign bit is a copy of it.
    function automatic logic fits_signed(input logic signed [31:0] value, input int width);
        logic signed [31:0] upper;
        upper = value >>> (width - 1);
        return (upper == 32'sd0) || (upper == -32'sd1);
    endfunction

    function automatic logic fits_unsigned(input logic signed [31:0] value, input int width);
        return (value >>> width) == 32'sd0;
    endfunction

    always_comb begin
        in_range = 1'b1;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP:
                if (is_immediate) in_range = fits_signed(immediate, ARITHMETIC_IMMEDIATE_W);
            OP_MOVE, OP_SHIFT:
                if (is_immediate) in_range = fits_unsigned(immediate, MOVE_SHIFT_IMMEDIATE_W);
            OP_LOAD_STORE:
                in_range = fits_signed(immediate, LOAD_STORE_IMMEDIATE_W);
            OP_CALL:
                in_range = fits_signed(immediate, CALL_IMMEDIATE_W);
            default:
                in_range = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Turns an operation request into one 32-bit instruction word (two for LOAD_CONSTANT).
// Define ENCODER_CHECK_EN to compile in the register-legality check.
module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [3:0]         operationCode,
    input  logic [4:0]         destination,
    input  logic [4:0]         source,
    input  logic               isImmediate,
    input  logic signed [31:0] immediate,
    input  logic [2:0]         mode,
    input  logic               variantBit,
    output logic               outValid,
    input  logic               outReady,
    output logic [31:0]        IR,
    output logic               error
);

    state_t             state_p0, state_nx;
    logic               error_p0, error_nx;
    logic               accept, reject, in_range, regs_ok;
    logic [3:0]         op_p0;
    logic [4:0]         dest_p0, src_p0;
    logic               imm_flag_p0, variant_p0;
    logic signed [31:0] imm_p0;
    logic [2:0]         mode_p0;
    logic [31:0]        word;

    assign inReady  = reset && (state_p0 == IDLE);
    assign accept   = inValid && inReady;
    assign outValid = (state_p0 != IDLE);
    assign error    = error_p0;

    immediate_range_check u_range (
        .opcode       (operationCode),
        .is_immediate (isImmediate),
        .immediate    (immediate),
        .in_range     (in_range)
    );

`ifdef ENCODER_CHECK_EN
    function automatic logic is_system_reg(input logic [4:0] r);
        return (r == REG_SP) || (r == REG_LR) || (r == REG_PC) || (r == REG_PSW);
    endfunction

    function automatic logic is_flow_reg(input logic [4:0] r);
        return (r == REG_LR) || (r == REG_PC) || (r == REG_PSW);
    endfunction

    always_comb begin
        regs_ok = 1'b1;
        case (operationCode)
            OP_ADD, OP_SUB:
                regs_ok = (destination != REG_PSW) && (source != REG_PSW);
            OP_MUL, OP_DIV, OP_CMP:
                regs_ok = !is_system_reg(destination) && !is_system_reg(source);
            OP_AND, OP_OR, OP_NOT, OP_TEST:
                regs_ok = !is_flow_reg(destination) && !is_flow_reg(source);
            OP_LOAD_STORE:
                regs_ok = (source != REG_PSW) && !((source == REG_PC) && (mode != 3'd0));
            default:
                regs_ok = 1'b1;
        endcase
    end
`else
    assign regs_ok = 1'b1;
`endif

    assign reject = (operationCode > OP_LAST) || !in_range || !regs_ok;

    // Stage p0: control state, reset to IDLE so any pending word is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_p0 <= IDLE;
            error_p0 <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            error_p0 <= error_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            op_p0       <= operationCode;
            dest_p0     <= destination;
            src_p0      <= source;
            imm_flag_p0 <= isImmediate;
            imm_p0      <= immediate;
            mode_p0     <= mode;
            variant_p0  <= variantBit;
        end
    end

    always_comb begin
        state_nx = state_p0;
        error_nx = 1'b0;
        case (state_p0)
            IDLE:
                if (accept) begin
                    if (reject)                               error_nx = 1'b1;
                    else if (operationCode == OP_LOAD_CONSTANT) state_nx = LDC_LOW;
                    else                                      state_nx = EMIT;
                end
            EMIT:     if (outReady) state_nx = IDLE;
            LDC_LOW:  if (outReady) state_nx = LDC_HIGH;
            LDC_HIGH: if (outReady) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        word = '0;
        word[OPCODE_LSB +: 4] = op_p0;
        case (op_p0)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP: begin
                word[DEST_LSB +: 5] = dest_p0;
                word[ARITHMETIC_IS_IMMEDIATE] = imm_flag_p0;
                if (imm_flag_p0)
                    word[ARITHMETIC_IMMEDIATE_W-1:0] = imm_p0[ARITHMETIC_IMMEDIATE_W-1:0];
                else
                    word[ARITHMETIC_SRC_LSB +: 5] = src_p0;
            end
            OP_AND, OP_OR, OP_NOT, OP_TEST: begin
                word[DEST_LSB +: 5] = dest_p0;
                word[SRC_LSB +: 5]  = src_p0;
            end
            OP_MOVE, OP_SHIFT: begin
                word[DEST_LSB +: 5] = dest_p0;
                word[MOVE_SHIFT_IS_IMMEDIATE] = imm_flag_p0;
                word[SHIFT_IS_LEFT] = (op_p0 == OP_SHIFT) && variant_p0;
                if (imm_flag_p0)
                    word[MOVE_SHIFT_IMMEDIATE_W-1:0] = imm_p0[MOVE_SHIFT_IMMEDIATE_W-1:0];
                else
                    word[SRC_LSB +: 5] = src_p0;
            end
            OP_LOAD_STORE: begin
                word[DEST_LSB +: 5] = dest_p0;
                word[SRC_LSB +: 5]  = src_p0;
                word[LOAD_STORE_MODE_LSB +: 3] = mode_p0;
                word[LOAD_STORE_IMMEDIATE_W-1:0] = imm_p0[LOAD_STORE_IMMEDIATE_W-1:0];
            end
            OP_LOAD_CONSTANT: begin
                word[DEST_LSB +: 5] = dest_p0;
                word[LDC_IS_HIGH]   = (state_p0 == LDC_HIGH);
                word[LDC_CONSTANT_W-1:0] = (state_p0 == LDC_HIGH) ? imm_p0[31:16] : imm_p0[15:0];
            end
            OP_CALL:
                word[CALL_IMMEDIATE_W-1:0] = imm_p0[CALL_IMMEDIATE_W-1:0];
            default: ;
        endcase
    end

    assign IR = outValid ? word : 32'd0;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized bench for instruction_encoder against an arithmetic reference model.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [3:0]  operationCode;
    logic [4:0]  destination;
    logic [4:0]  source;
    logic        isImmediate;
    logic [31:0] immediate;
    logic [2:0]  mode;
    logic        variantBit;
    logic        outValid;
    logic        outReady;
    logic [31:0] IR;
    logic        error;

    int checks = 0;
    int errors = 0;
    logic [31:0] got[$];

    typedef struct {
        logic [3:0] op;
        logic [4:0] dest;
        logic [4:0] src;
        bit         isimm;
        int         imm;
        logic [2:0] mode;
        bit         variant;
    } req_t;

    int edge_vals[14] = '{131071, 131072, -131072, -131073, 511, 512, -512, -513,
                          262143, 262144, -262144, -262145, 31, 32};

    instruction_encoder dut (
        .clock         (clock),
        .reset         (reset),
        .inValid       (inValid),
        .inReady       (inReady),
        .operationCode (operationCode),
        .destination   (destination),
        .source        (source),
        .isImmediate   (isImmediate),
        .immediate     (immediate),
        .mode          (mode),
        .variantBit    (variantBit),
        .outValid      (outValid),
        .outReady      (outReady),
        .IR            (IR),
        .error         (error)
    );

    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s,
                                input bit ii, input int imm, input logic [2:0] m, input bit v);
        req_t r;
        r.op = op; r.dest = d; r.src = s; r.isimm = ii; r.imm = imm; r.mode = m; r.variant = v;
        return r;
    endfunction

    function automatic longint pw(input int n);
        return longint'(1) << n;
    endfunction

    function automatic longint wrap(input longint v, input int bits);
        return ((v % pw(bits)) + pw(bits)) % pw(bits);
    endfunction

    function automatic bit fits_signed(input longint v, input int bits);
        return (v >= -pw(bits - 1)) && (v <= pw(bits - 1) - 1);
    endfunction

    // Reference: legality and expected words built from field weights.
    function automatic void model(input req_t r, output bit rej, output logic [31:0] w0,
                                  output logic [31:0] w1, output int n);
        longint imm;
        longint base;
        longint sum;
        longint u;
        bit arith, logic_op, movsh;
        imm      = longint'(r.imm);
        arith    = (r.op <= OP_CMP);
        logic_op = (r.op >= OP_AND) && (r.op <= OP_TEST);
        movsh    = (r.op == OP_MOVE) || (r.op == OP_SHIFT);
        rej = 0; n = 1; w1 = 32'd0;
        if (r.op > OP_INTERRUPT) rej = 1;
        if (arith && r.isimm && !fits_signed(imm, 18)) rej = 1;
        if (movsh && r.isimm && (imm < 0 || imm > 31)) rej = 1;
        if (r.op == OP_LOAD_STORE && !fits_signed(imm, 10)) rej = 1;
        if (r.op == OP_CALL && !fits_signed(imm, 19)) rej = 1;
`ifdef ENCODER_CHECK_EN
        if ((r.op == OP_ADD || r.op == OP_SUB) && (r.dest == REG_PSW || r.src == REG_PSW)) rej = 1;
        if ((r.op == OP_MUL || r.op == OP_DIV || r.op == OP_CMP) && (r.dest >= REG_SP || r.src >= REG_SP)) rej = 1;
        if (logic_op && (r.dest >= REG_PC || r.src >= REG_PC || r.dest == REG_LR || r.src == REG_LR)) rej = 1;
        if (r.op == OP_LOAD_STORE && (r.src == REG_PSW || (r.src == REG_PC && r.mode != 0))) rej = 1;
`endif
        base = longint'(r.op) * pw(28);
        sum  = base + longint'(r.dest) * pw(23);
        if (arith)
            sum += r.isimm ? (pw(22) + wrap(imm, 18)) : longint'(r.src) * pw(17);
        else if (logic_op)
            sum += longint'(r.src) * pw(18);
        else if (movsh)
            sum += (r.isimm ? (pw(17) + imm) : longint'(r.src) * pw(18))
                 + ((r.op == OP_SHIFT && r.variant) ? pw(16) : 0);
        else if (r.op == OP_LOAD_STORE)
            sum += longint'(r.src) * pw(18) + longint'(r.mode) * pw(15) + wrap(imm, 10);
        else if (r.op == OP_LOAD_CONSTANT) begin
            u   = wrap(imm, 32);
            w1  = 32'(sum + pw(16) + u / pw(16));
            sum += u % pw(16);
            n = 2;
        end else
            sum = base + ((r.op == OP_CALL) ? wrap(imm, 19) : 0);
        w0 = 32'(sum);
    endfunction

    task automatic run_txn(input req_t r, input int stall);
        bit rej;
        logic [31:0] w0, w1, exp_w;
        int n, guard;
        model(r, rej, w0, w1, n);
        guard = 0;
        while (!inReady && guard < 20) begin
            step();
            guard++;
        end
        check("in_ready", inReady, 1);
        inValid = 1; operationCode = r.op; destination = r.dest; source = r.src;
        isImmediate = r.isimm; immediate = r.imm; mode = r.mode; variantBit = r.variant;
        step();
        inValid = 0;
        got.delete();
        if (rej) begin
            check("error_pulse", error, 1);
            check("reject_no_word", outValid, 0);
            step();
            check("error_clear", error, 0);
            check("reject_idle", inReady, 1);
        end else begin
            check("no_error", error, 0);
            for (int k = 0; k < n; k++) begin
                exp_w = (k == 0) ? w0 : w1;
                outReady = 0;
                for (int s = 0; s < stall; s++) begin
                    check("stall_valid", outValid, 1);
                    check("stall_ir", IR, exp_w);
                    check("stall_in_ready", inReady, 0);
                    step();
                end
                outReady = 1;
                check("out_valid", outValid, 1);
                check("ir", IR, exp_w);
                got.push_back(IR);
                step();
            end
            check("back_idle_valid", outValid, 0);
            check("back_idle_ready", inReady, 1);
        end
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 1) == 0) return 5'(28 + $urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic int pick_imm();
        int c;
        c = int'($urandom_range(0, 19));
        if (c < 14) return edge_vals[c];
        if (c < 17) return int'($urandom_range(0, 40)) - 8;
        return int'($urandom);
    endfunction

    initial begin
        req_t rr;
        reset = 0; inValid = 0; outReady = 0; operationCode = 0; destination = 0; source = 0;
        isImmediate = 0; immediate = 0; mode = 0; variantBit = 0;
        step();
        step();
        check("rst_in_ready", inReady, 0);
        check("rst_out_valid", outValid, 0);
        check("rst_ir", IR, 0);
        check("rst_error", error, 0);
        reset = 1;
        #1;
        check("rst_release_in_ready", inReady, 1);

        run_txn(mk(OP_ADD, 5'd1, 5'd2, 0, 0, 3'd0, 0), 0);
        check("add_count", got.size(), 1);
        check("add_word", got[0], 32'h0084_0000);

        run_txn(mk(OP_LOAD_CONSTANT, 5'd3, 5'd0, 0, 32'h1234_5678, 3'd0, 0), 1);
        check("ldc_count", got.size(), 2);
        check("ldc_low", got[0], 32'hC180_5678);
        check("ldc_high", got[1], 32'hC181_1234);

        run_txn(mk(OP_ADD, 5'd1, 5'd0, 1, 131071, 3'd0, 0), 0);
        check("add_imm_max", got[0], 32'h00C1_FFFF);
        run_txn(mk(OP_ADD, 5'd1, 5'd0, 1, 131072, 3'd0, 0), 0);
        run_txn(mk(OP_ADD, 5'd1, 5'd0, 1, -131072, 3'd0, 0), 0);
        run_txn(mk(OP_ADD, 5'd1, 5'd0, 1, -131073, 3'd0, 0), 0);

        run_txn(mk(OP_SUB, 5'd4, 5'd5, 0, 0, 3'd0, 0), 5);
        run_txn(mk(OP_MUL, REG_SP, 5'd1, 0, 0, 3'd0, 0), 0);

        run_txn(mk(OP_LOAD_STORE, 5'd2, 5'd3, 0, 511, 3'd5, 0), 0);
        run_txn(mk(OP_LOAD_STORE, 5'd2, 5'd3, 0, 512, 3'd5, 0), 0);
        run_txn(mk(OP_LOAD_STORE, 5'd2, 5'd3, 0, -512, 3'd1, 0), 0);
        run_txn(mk(OP_LOAD_STORE, 5'd2, 5'd3, 0, -513, 3'd1, 0), 0);
        run_txn(mk(OP_CALL, 5'd7, 5'd9, 1, 262143, 3'd0, 0), 0);
        run_txn(mk(OP_CALL, 5'd7, 5'd9, 1, 262144, 3'd0, 0), 0);
        run_txn(mk(OP_CALL, 5'd0, 5'd0, 0, -262144, 3'd0, 0), 2);
        run_txn(mk(OP_MOVE, 5'd6, 5'd0, 1, 31, 3'd0, 1), 0);
        run_txn(mk(OP_MOVE, 5'd6, 5'd0, 1, 32, 3'd0, 0), 0);
        run_txn(mk(OP_SHIFT, 5'd6, 5'd0, 1, -1, 3'd0, 1), 0);
        run_txn(mk(OP_SHIFT, 5'd6, 5'd8, 0, 999, 3'd0, 1), 0);
        run_txn(mk(OP_AND, 5'd1, 5'd2, 1, 32'h7FFF_FFFF, 3'd7, 1), 0);
        check("and_ignores_imm", got[0], 32'h5088_0000);
        run_txn(mk(4'd15, 5'd1, 5'd2, 0, 0, 3'd0, 0), 0);
        run_txn(mk(OP_INTERRUPT, 5'd31, 5'd31, 1, -1, 3'd7, 1), 1);
        check("interrupt_word", got[0], 32'hE000_0000);

        // Reset while the high half of a LOAD_CONSTANT is pending.
        inValid = 1; operationCode = OP_LOAD_CONSTANT; destination = 5'd3; source = 5'd0;
        isImmediate = 0; immediate = 32'hCAFE_BEEF; mode = 3'd0; variantBit = 0; outReady = 1;
        step();
        inValid = 0;
        check("mid_low_ir", IR, 32'hC180_BEEF);
        step();
        check("mid_high_valid", outValid, 1);
        check("mid_high_ir", IR, 32'hC181_CAFE);
        reset = 0; outReady = 0;
        step();
        check("mid_rst_valid", outValid, 0);
        check("mid_rst_ir", IR, 0);
        check("mid_rst_in_ready", inReady, 0);
        check("mid_rst_error", error, 0);
        reset = 1;
        #1;
        check("mid_release_in_ready", inReady, 1);
        step();
        check("mid_discarded", outValid, 0);

        for (int t = 0; t < 300; t++) begin
            rr.op = 4'($urandom_range(0, 15));
            rr.dest = pick_reg();
            rr.src = pick_reg();
            rr.isimm = 1'($urandom_range(0, 1));
            rr.imm = pick_imm();
            rr.mode = 3'($urandom_range(0, 7));
            rr.variant = 1'($urandom_range(0, 1));
            run_txn(rr, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
